// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin arbiter in front of one shared bitwise logic unit (AND/OR/XOR/NAND).
// Optional macro LU_ARB_STATS_EN adds per-requester completion counters done_cnt0/done_cnt1.
//
// state | meaning
// IDLE  | waiting for a request; grants one requester combinationally
// EXEC  | computing the result from the latched op/a/b
// RESP  | holding rsp_valid/rsp_id/rsp_data until rsp_ready
module logic_unit_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data
`ifdef LU_ARB_STATS_EN
  ,
  output logic [15:0]      done_cnt0,
  output logic [15:0]      done_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic             last_grant;
  logic             win;
  logic             accept;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             id_q;
  logic [WIDTH-1:0] lu_res;

  // On a tie the requester not granted last wins; a lone requester always wins.
  always_comb begin
    if (req0_valid && req1_valid) win = ~last_grant;
    else                          win = req1_valid;
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          accept     = 1'b1;
          req0_ready = ~win;
          req1_ready = win;
          state_nxt  = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (op_q)
      2'b00:   lu_res = a_q & b_q;
      2'b01:   lu_res = a_q | b_q;
      2'b10:   lu_res = a_q ^ b_q;
      default: lu_res = ~(a_q & b_q);
    endcase
  end

  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Pointer starts at 1 so requester 0 takes the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      op_q       <= 2'b00;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
    end else begin
      if (accept) begin
        last_grant <= win;
        id_q       <= win;
        op_q       <= win ? req1_op : req0_op;
        a_q        <= win ? req1_a  : req0_a;
        b_q        <= win ? req1_b  : req0_b;
      end
      if (state == EXEC) begin
        rsp_data <= lu_res;
        rsp_id   <= id_q;
      end
    end
  end

`ifdef LU_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt0 <= 16'h0000;
      done_cnt1 <= 16'h0000;
    end else if (rsp_valid && rsp_ready) begin
      if (rsp_id) done_cnt1 <= done_cnt1 + 16'h0001;
      else        done_cnt0 <= done_cnt0 + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model. Define LU_ARB_STATS_EN to also check the counters.
module tb_logic_unit_arbiter;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [WIDTH-1:0] rsp_data;
`ifdef LU_ARB_STATS_EN
  logic [15:0]      done_cnt0, done_cnt1;
`endif

  int total = 0;
  int bad   = 0;

  logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data)
`ifdef LU_ARB_STATS_EN
    ,
    .done_cnt0  (done_cnt0),
    .done_cnt1  (done_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] lu_ref(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  // Reference model: an accepted op is visible two cycles later and held until taken.
  logic             m_busy = 1'b0;
  int               m_age  = 0;
  logic             m_last = 1'b1;
  logic             m_id   = 1'b0;
  logic [WIDTH-1:0] m_data = '0;
  logic [15:0]      m_cnt0 = 16'h0, m_cnt1 = 16'h0;
  logic             exp_r0, exp_r1, exp_rv;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_age  = 0;
      m_last = 1'b1;
      m_cnt0 = 16'h0;
      m_cnt1 = 16'h0;
      check_eq("rst_rsp_valid", rsp_valid, 1'b0);
      check_eq("rst_rsp_data", rsp_data, 16'h0);
`ifdef LU_ARB_STATS_EN
      check_eq("rst_cnt0", done_cnt0, 16'h0);
      check_eq("rst_cnt1", done_cnt1, 16'h0);
`endif
    end else begin
      exp_r0 = 1'b0;
      exp_r1 = 1'b0;
      if (!m_busy) begin
        if (req0_valid && req1_valid) begin
          if (m_last) exp_r0 = 1'b1; else exp_r1 = 1'b1;
        end else if (req0_valid) exp_r0 = 1'b1;
        else if (req1_valid)     exp_r1 = 1'b1;
      end
      exp_rv = m_busy && (m_age >= 2);
      check_eq("m_req0_ready", req0_ready, exp_r0);
      check_eq("m_req1_ready", req1_ready, exp_r1);
      check_eq("m_rsp_valid", rsp_valid, exp_rv);
      if (exp_rv) begin
        check_eq("m_rsp_id", rsp_id, m_id);
        check_eq("m_rsp_data", rsp_data, m_data);
      end
`ifdef LU_ARB_STATS_EN
      check_eq("m_cnt0", done_cnt0, m_cnt0);
      check_eq("m_cnt1", done_cnt1, m_cnt1);
`endif
      if (exp_r0 || exp_r1) begin
        m_busy = 1'b1;
        m_age  = 1;
        m_last = exp_r1;
        m_id   = exp_r1;
        m_data = exp_r1 ? lu_ref(req1_op, req1_a, req1_b) : lu_ref(req0_op, req0_a, req0_b);
      end else if (m_busy) begin
        if (m_age < 2) m_age++;
        else if (rsp_ready) begin
          m_busy = 1'b0;
          if (m_id) m_cnt1++; else m_cnt0++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_op = 2'd0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = 2'd0; req1_a = '0; req1_b = '0;
    rsp_ready  = 1'b1;
  endtask

  // Issue one op from a single requester and wait (bounded) for its response to be taken.
  task automatic single_op(input logic id, input logic [1:0] op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b);
    int n;
    rsp_ready = 1'b1;
    if (id) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    n = 0;
    @(negedge clk);
    while (!(id ? req1_ready : req0_ready) && n < 20) begin
      step(); @(negedge clk); n++;
    end
    check_eq("op_accept_timeout", n < 20, 1'b1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      step(); @(negedge clk); n++;
    end
    check_eq("op_rsp_timeout", n < 20, 1'b1);
    check_eq("op_rsp_id", rsp_id, id);
    step();
  endtask

  logic acc0, acc1;
  int   k, n;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    do_reset();

    // req0 AND with zero-wait consumer: accept N, rsp_valid at N+2.
    req0_valid = 1'b1; req0_op = 2'd0; req0_a = 16'hFFFF; req0_b = 16'h0000;
    @(negedge clk);
    check_eq("s1_accept", req0_ready, 1'b1);
    step(); req0_valid = 1'b0;
    @(negedge clk);
    check_eq("s1_exec_valid", rsp_valid, 1'b0);
    step(); @(negedge clk);
    check_eq("s1_rsp_valid", rsp_valid, 1'b1);
    check_eq("s1_rsp_id", rsp_id, 1'b0);
    check_eq("s1_rsp_data", rsp_data, 16'h0000);
    step(); @(negedge clk);
    check_eq("s1_back_idle", rsp_valid, 1'b0);

    // Both valid from reset: req0 first (OR), then req1 (XOR).
    do_reset();
    req0_valid = 1'b1; req0_op = 2'd1; req0_a = 16'h1234; req0_b = 16'h5678;
    req1_valid = 1'b1; req1_op = 2'd2; req1_a = 16'hABCD; req1_b = 16'hEF01;
    @(negedge clk);
    check_eq("s2_first_r0", req0_ready, 1'b1);
    check_eq("s2_first_r1", req1_ready, 1'b0);
    step(); req0_valid = 1'b0;
    step(); @(negedge clk);
    check_eq("s2_rsp0_id", rsp_id, 1'b0);
    check_eq("s2_rsp0_data", rsp_data, 16'h567C);
    step(); @(negedge clk);
    check_eq("s2_second_r1", req1_ready, 1'b1);
    step(); req1_valid = 1'b0;
    step(); @(negedge clk);
    check_eq("s2_rsp1_id", rsp_id, 1'b1);
    check_eq("s2_rsp1_data", rsp_data, 16'h44CC);
    step();

    // req1 NAND with consumer stalled for 5 cycles; req0 waiting must not be accepted.
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_op = 2'd3; req1_a = 16'hFFFF; req1_b = 16'hFFFF;
    @(negedge clk);
    check_eq("s3_accept", req1_ready, 1'b1);
    step(); req1_valid = 1'b0; req1_a = 16'h0F0F;
    req0_valid = 1'b1; req0_op = 2'd0; req0_a = 16'hAAAA; req0_b = 16'hFFFF;
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("s3_hold_valid", rsp_valid, 1'b1);
      check_eq("s3_hold_data", rsp_data, 16'h0000);
      check_eq("s3_hold_id", rsp_id, 1'b1);
      check_eq("s3_no_accept", req0_ready, 1'b0);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("s3_handshake_no_accept", req0_ready, 1'b0);
    step(); @(negedge clk);
    check_eq("s3_idle_valid", rsp_valid, 1'b0);
    check_eq("s3_next_accept", req0_ready, 1'b1);
    step(); req0_valid = 1'b0;
    repeat (3) step();

    // Continuous tie for 6 ops: grants alternate 0,1,0,1,0,1 from reset.
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    k = 0; n = 0;
    while (k < 6 && n < 40) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        check_eq("s4_grant_order", req1_ready, k % 2);
        k++;
      end
      step();
      req0_a = 16'($urandom); req1_a = 16'($urandom);
      n++;
    end
    check_eq("s4_grant_count", k, 6);
    idle_inputs();
    repeat (4) step();

    // Reset during EXEC after a req0 grant: no response, next tie goes to req0.
    req0_valid = 1'b1; req0_op = 2'd2; req0_a = 16'h00FF; req0_b = 16'h0F0F;
    @(negedge clk);
    check_eq("s5_accept", req0_ready, 1'b1);
    step(); req0_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("s5_rst_valid", rsp_valid, 1'b0);
    step();
    rst_n = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    check_eq("s5_no_rsp", rsp_valid, 1'b0);
    check_eq("s5_tie_r0", req0_ready, 1'b1);
    check_eq("s5_tie_r1", req1_ready, 1'b0);
    step();
    idle_inputs();
    repeat (3) step();

`ifdef LU_ARB_STATS_EN
    do_reset();
    single_op(1'b0, 2'd0, 16'h1111, 16'h2222);
    single_op(1'b1, 2'd1, 16'h3333, 16'h4444);
    single_op(1'b0, 2'd2, 16'h5555, 16'h6666);
    single_op(1'b1, 2'd3, 16'h7777, 16'h8888);
    single_op(1'b0, 2'd1, 16'h9999, 16'hAAAA);
    @(negedge clk);
    check_eq("s6_done_cnt0", done_cnt0, 16'd3);
    check_eq("s6_done_cnt1", done_cnt1, 16'd2);
    step();
`else
    single_op(1'b1, 2'd3, 16'hF0F0, 16'hFF00);
`endif

    // Randomized traffic: valids held until accepted, operands scrambled after accept.
    do_reset();
    acc0 = 1'b0; acc1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!req0_valid || acc0) begin
        req0_valid = ($urandom_range(0, 2) == 0);
        req0_op = 2'($urandom); req0_a = 16'($urandom); req0_b = 16'($urandom);
      end
      if (!req1_valid || acc1) begin
        req1_valid = ($urandom_range(0, 2) == 0);
        req1_op = 2'($urandom); req1_a = 16'($urandom); req1_b = 16'($urandom);
      end
      rsp_ready = 1'($urandom);
      @(negedge clk);
      acc0 = req0_ready;
      acc1 = req1_ready;
      step();
    end
    idle_inputs();
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_op  input  2  requester 0 opcode: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-007 req0_a, req0_b  input  WIDTH  requester 0 operands.
REQ-008 req1_valid, req1_ready, req1_op, req1_a, req1_b: same as REQ-004 to REQ-007, for requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer takes result.
REQ-011 rsp_id  output  1  requester that issued the result.
REQ-012 rsp_data  output  WIDTH  bitwise result.
REQ-013 done_cnt0, done_cnt1  output  16  completed-operation counters, present only under LU_ARB_STATS_EN.

Function
REQ-014 Block SHALL share one WIDTH-bit bitwise logic unit between two requesters through FSM states IDLE, EXEC and RESP.
REQ-015 In IDLE, if any reqN_valid is high, the block SHALL pick a winner, drive that requester's reqN_ready high combinationally, latch its op/a/b/id and go to EXEC.
REQ-016 In IDLE, if neither valid is high, the block SHALL stay in IDLE with both ready signals low.
REQ-017 Only one reqN_ready SHALL be high in any cycle, and both SHALL be low in EXEC and RESP.
REQ-018 Arbitration SHALL be round-robin: when both requesters are valid, the requester not granted last wins; a single valid requester always wins.
REQ-019 The last-grant pointer SHALL update only on an accepted transfer.
REQ-020 In EXEC, the block SHALL register rsp_data as op applied bitwise to the latched a and b, SHALL copy the latched id into rsp_id, and SHALL go to RESP.
REQ-021 NAND SHALL be the bitwise inverse of AND over all WIDTH bits.
REQ-022 In RESP, rsp_valid SHALL be high, and rsp_data/rsp_id SHALL hold stable until rsp_ready is high.
REQ-023 When rsp_ready is high in RESP, the block SHALL return to IDLE, with rsp_valid low in the next cycle.
REQ-024 Latency: accepted in cycle N, rsp_valid high in cycle N+2 with zero-wait-state rsp_ready.
REQ-025 Maximum throughput: one operation per 3 cycles.
REQ-026 A new request SHALL NOT be accepted in the cycle rsp handshakes; it is accepted in the following IDLE cycle.
REQ-027 Requester inputs SHALL be ignored outside the accept cycle, so operand changes after accept do not affect the result.
REQ-028 An unaccepted requester keeps reqN_valid asserted; the block imposes no timeout.

Reset
REQ-029 When rst_n is low, the block SHALL asynchronously force:
  - state to IDLE;
  - rsp_valid to 0, rsp_id to 0 and rsp_data to 0;
  - last-grant pointer to 1, so requester 0 wins the first tie;
  - done counters to 0.
REQ-030 Reset asserted in EXEC or RESP SHALL discard the in-flight operation, and no rsp_valid SHALL follow it.
REQ-031 After rst_n deasserts, the block SHALL accept a request on the first rising edge.

Configuration
REQ-032 Macro LU_ARB_STATS_EN defined: the block SHALL provide done_cnt0/done_cnt1, each incrementing by 1 on each rsp handshake with matching rsp_id and wrapping from FFFF to 0000.
REQ-033 Macro LU_ARB_STATS_EN undefined: the block SHALL omit the done_cnt ports and counter logic, and all other behaviour SHALL be identical.

Verification
REQ-034 Scenario req0 only, op=00, a=FFFF, b=0000, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_id=0, rsp_data=0000.
REQ-035 Scenario both requesters valid from reset:
  - req0: op=01, a=1234, b=5678;
  - req1: op=10, a=ABCD, b=EF01;
  - required response: req0 served first with rsp_data=567C, then req1 with rsp_data=44CC;
  - ready signals never high together.
REQ-036 Scenario req1 op=11, a=FFFF, b=FFFF, rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data=0000 and rsp_id=1 held stable all 5 cycles, and no new accept occurs; then rsp_ready=1 -> IDLE.
REQ-037 Scenario both requesters continuously valid for 6 operations -> grant order 0,1,0,1,0,1.
REQ-038 Scenario rst_n pulsed low during EXEC -> rsp_valid stays 0, state returns to IDLE, and the next tie is granted to req0.
REQ-039 Scenario with LU_ARB_STATS_EN defined, 3 req0 and 2 req1 completions -> done_cnt0=3 and done_cnt1=2.
